// File: rtl/instrumented_adder_sequencer.sv
// instrumented_adder_sequencer
//   Runs one delay measurement on the instrumented adder. It loads the operands,
//   closes the adder's ring-oscillator loop, and counts ring edges over a fixed
//   window. The window is repeated R times. The accumulated edge count and the
//   final sum are returned to the logic-analyser bank.
// Ports
//   wb_clk_i, wb_rst_i       : clock, asynchronous active-high reset
//   start, abort             : run control (start only in IDLE, abort anywhere else)
//   a_value, b_value         : operands, sampled in LOAD
//   window_cycles, repeats   : window length / window count, sampled in LOAD (0 -> 1)
//   ring_in                  : ring-oscillator tap, asynchronous to wb_clk_i
//   sum_in                   : adder sum
//   a_input, b_input         : registered operands driven to the adder
//   ring_enable, busy, done  : loop enable, run in progress, completion pulse
//   edge_count, sum_capture  : measurement results
//   overflow                 : sticky saturation flag for edge_count
`timescale 1ns/1ps

module instrumented_adder_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_value,
  input  logic [WIDTH-1:0] b_value,
  input  logic [15:0]      window_cycles,
  input  logic [7:0]       repeats,
  input  logic             ring_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] a_input,
  output logic [WIDTH-1:0] b_input,
  output logic             ring_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic [WIDTH-1:0] sum_capture,
  output logic             overflow
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned REP_W   = 8;
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_MEASURE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] win_len;
  logic [REP_W-1:0]   rep;
  logic [REP_W-1:0]   rep_len;
  logic [REP_W-1:0]   rep_inc;

  logic               ring_s1;
  logic               ring_s2;
  logic               ring_d;
  logic               ring_edge;

  // Datapath strobes decoded by the FSM
  logic               clear_run;
  logic               load_ops;
  logic               load_settle;
  logic               load_window;
  logic               count_tick;
  logic               count_en;
  logic               capture_en;

  // Rising edge of the synchronised ring tap
  assign ring_edge = ring_s2 & ~ring_d;
  assign rep_inc   = rep + REP_W'(1);

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobe decode
  always_comb begin
    state_next  = state;
    clear_run   = 1'b0;
    load_ops    = 1'b0;
    load_settle = 1'b0;
    load_window = 1'b0;
    count_tick  = 1'b0;
    count_en    = 1'b0;
    capture_en  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          clear_run  = 1'b1;
        end
      end
      S_LOAD: begin
        state_next  = S_SETTLE;
        load_ops    = 1'b1;
        load_settle = 1'b1;
      end
      S_SETTLE: begin
        if (timer == '0) begin
          state_next  = S_MEASURE;
          load_window = 1'b1;
        end else begin
          count_tick = 1'b1;
        end
      end
      S_MEASURE: begin
        count_en = 1'b1;
        if (timer == '0) begin
          state_next = S_CAPTURE;
        end else begin
          count_tick = 1'b1;
        end
      end
      S_CAPTURE: begin
        capture_en = 1'b1;
        if (rep_inc == rep_len) begin
          state_next = S_DONE;
        end else begin
          state_next  = S_SETTLE;
          load_settle = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort beats every transition; results keep whatever was accumulated so far
    if (abort && (state != S_IDLE)) begin
      state_next  = S_IDLE;
      clear_run   = 1'b0;
      load_ops    = 1'b0;
      load_settle = 1'b0;
      load_window = 1'b0;
      count_tick  = 1'b0;
      count_en    = 1'b0;
      capture_en  = 1'b0;
    end
  end

  // Ring synchroniser and edge-detect history
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ring_s1 <= 1'b0;
      ring_s2 <= 1'b0;
      ring_d  <= 1'b0;
    end else begin
      ring_s1 <= ring_in;
      ring_s2 <= ring_s1;
      ring_d  <= ring_s2;
    end
  end

  // Status outputs registered from the next state so they line up with the state
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ring_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ring_enable <= (state_next == S_SETTLE) || (state_next == S_MEASURE);
      busy        <= (state_next != S_IDLE);
      done        <= (state_next == S_DONE);
    end
  end

  // Run configuration and operands
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      a_input <= '0;
      b_input <= '0;
      win_len <= '0;
      rep_len <= '0;
    end else if (load_ops) begin
      a_input <= a_value;
      b_input <= b_value;
      win_len <= (window_cycles == '0) ? TIMER_W'(1) : window_cycles;
      rep_len <= (repeats == '0) ? REP_W'(1) : repeats;
    end
  end

  // Phase timer: counts down SETTLE then MEASURE lengths
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      timer <= '0;
    end else if (load_settle) begin
      timer <= SETTLE_LAST;
    end else if (load_window) begin
      timer <= win_len - TIMER_W'(1);
    end else if (count_tick) begin
      timer <= timer - TIMER_W'(1);
    end
  end

  // Edge accumulator with saturation and sticky overflow
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      edge_count <= '0;
      overflow   <= 1'b0;
    end else if (clear_run) begin
      edge_count <= '0;
      overflow   <= 1'b0;
    end else if (count_en && ring_edge) begin
      if (&edge_count) begin
        overflow <= 1'b1;
      end else begin
        edge_count <= edge_count + CNT_W'(1);
      end
    end
  end

  // Repeat counter and sum capture
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rep         <= '0;
      sum_capture <= '0;
    end else if (clear_run) begin
      rep <= '0;
    end else if (capture_en) begin
      rep         <= rep_inc;
      sum_capture <= sum_in;
    end
  end

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// tb_instrumented_adder_sequencer
//   Table-driven directed runs, randomized runs scored against a cycle-schedule
//   model, plus hand-written reset sequences. CNT_W is narrowed to 8 so that
//   saturation is reachable quickly.
`timescale 1ns/1ps

module tb_instrumented_adder_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;
  localparam int          S     = 4;
  localparam int          MAXC  = 2048;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] a_value = '0;
  logic [WIDTH-1:0] b_value = '0;
  logic [15:0]      window_cycles = '0;
  logic [7:0]       repeats = '0;
  logic             ring_in = 1'b0;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic             ring_enable;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edge_count;
  logic [WIDTH-1:0] sum_capture;
  logic             overflow;

  always #5 clk = ~clk;

  // Behavioural adder feeding the sum back
  assign sum_in = a_input + b_input;

  instrumented_adder_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .SETTLE_CYCLES(S)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .start(start),
    .abort(abort),
    .a_value(a_value),
    .b_value(b_value),
    .window_cycles(window_cycles),
    .repeats(repeats),
    .ring_in(ring_in),
    .sum_in(sum_in),
    .a_input(a_input),
    .b_input(b_input),
    .ring_enable(ring_enable),
    .busy(busy),
    .done(done),
    .edge_count(edge_count),
    .sum_capture(sum_capture),
    .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;
  logic wave [MAXC];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          w;
    int          r;
    int          pattern;
    int          abort_c;
    int          restart_c;
    int          lat;
    int          edges;
    int          ovf;
    logic [31:0] sum;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Ring waveform, indexed by the clock edge at which it is sampled
  task automatic fill_wave(input int pattern);
    for (int n = 0; n < MAXC; n++) begin
      case (pattern)
        1:       wave[n] = 1'(n >> 1);
        2:       wave[n] = 1'(n);
        3:       wave[n] = 1'($urandom_range(0, 1));
        default: wave[n] = 1'b0;
      endcase
    end
  endtask

  // Phase occupied in cycle c (cycle c ends at clock edge c; start sampled at edge 0)
  // 0 idle, 1 load, 2 settle, 3 measure, 4 capture, 5 done
  function automatic int phase_of(input int c, input int w, input int r, input int stop);
    int per;
    int k;
    int off;
    if (stop > 0 && c > stop) return 0;
    if (c < 1) return 0;
    if (c == 1) return 1;
    per = S + w + 1;
    k   = c - 2;
    if (k / per >= r) return (k == r * per) ? 5 : 0;
    off = k % per;
    if (off < S) return 2;
    if (off < S + w) return 3;
    return 4;
  endfunction

  // A rising ring edge between samples n-1 and n is seen by the counter in cycle n+2
  task automatic model_edges(input int w, input int r, input int stop, input int last,
                             output int cnt, output int ovf);
    cnt = 0;
    ovf = 0;
    for (int c = 3; c <= last; c++) begin
      if (phase_of(c, w, r, stop) == 3 && !(stop > 0 && c == stop) && wave[c-2] && !wave[c-3]) begin
        if (cnt == CMAX) ovf = 1;
        else cnt++;
      end
    end
  endtask

  task automatic run(input string tag, input vec_t v, input bit mid_change);
    int we;
    int re;
    int last;
    int done_at;
    int done_n;
    int bad_c;
    int ph;
    we      = (v.w == 0) ? 1 : v.w;
    re      = (v.r == 0) ? 1 : v.r;
    last    = (v.lat > 0) ? v.lat : v.abort_c;
    done_at = -1;
    done_n  = 0;
    bad_c   = 0;
    @(negedge clk);
    a_value       = v.a;
    b_value       = v.b;
    window_cycles = 16'(v.w);
    repeats       = 8'(v.r);
    start         = 1'b1;
    abort         = (v.abort_c == 0);
    ring_in       = wave[0];
    for (int c = 1; c <= last + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      ph = phase_of(c, we, re, v.abort_c);
      if (done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (bad_c == 0 && (busy !== (ph != 0) || ring_enable !== (ph == 2 || ph == 3) ||
                         done !== (ph == 5)))
        bad_c = c;
      if (c == v.abort_c) abort = 1'b1;
      if (c == v.restart_c) start = 1'b1;
      if (mid_change && c == 3) begin
        a_value       = $urandom;
        b_value       = $urandom;
        window_cycles = 16'($urandom);
        repeats       = 8'($urandom);
      end
      ring_in = wave[c];
    end
    check({tag, "/done_cycle"}, 64'(done_at), 64'((v.lat > 0) ? v.lat : -1));
    check({tag, "/done_pulses"}, 64'(done_n), 64'((v.lat > 0) ? 1 : 0));
    check({tag, "/trace_first_bad_cycle"}, 64'(bad_c), 64'(0));
    check({tag, "/edge_count"}, 64'(edge_count), 64'(v.edges));
    check({tag, "/overflow"}, 64'(overflow), 64'(v.ovf));
    check({tag, "/sum_capture"}, 64'(sum_capture), 64'(v.sum));
    check({tag, "/a_input"}, 64'(a_input), 64'(v.a));
    check({tag, "/b_input"}, 64'(b_input), 64'(v.b));
  endtask

  vec_t vecs [8];
  vec_t rv;
  logic [31:0] exp_sum;

  initial begin
    // a, b, w, r, pattern, abort_c, restart_c, latency, edges, ovf, sum
    vecs[0] = '{32'd5, 32'd7, 10, 1, 0, -1, -1, 17, 0, 0, 32'd12};
    vecs[1] = '{32'd100, 32'd200, 100, 3, 1, -1, -1, 317, 75, 0, 32'd300};
    vecs[2] = '{32'hFFFF_FFF0, 32'h20, 1000, 1, 2, -1, -1, 1007, 255, 1, 32'h10};
    vecs[3] = '{32'd9, 32'd9, 20, 1, 0, 10, -1, 0, 0, 0, 32'h10};
    vecs[4] = '{32'd3, 32'd4, 0, 0, 0, -1, 3, 8, 0, 0, 32'd7};
    vecs[5] = '{32'd11, 32'd22, 20, 2, 1, 19, -1, 0, 3, 0, 32'd7};
    vecs[6] = '{32'd50, 32'd60, 5, 2, 2, 11, -1, 0, 2, 0, 32'd7};
    vecs[7] = '{32'd1, 32'd2, 3, 2, 0, 0, -1, 18, 0, 0, 32'd3};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset/busy", 64'(busy), 64'(0));
    check("reset/ring_enable", 64'(ring_enable), 64'(0));
    check("reset/done", 64'(done), 64'(0));
    check("reset/edge_count", 64'(edge_count), 64'(0));
    check("reset/sum_capture", 64'(sum_capture), 64'(0));
    check("reset/a_input", 64'(a_input), 64'(0));
    check("reset/overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    // Abort while idle must be ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort/busy", 64'(busy), 64'(0));

    for (int i = 0; i < 8; i++) begin
      fill_wave(vecs[i].pattern);
      run($sformatf("vec%0d", i), vecs[i], 1'b0);
    end
    exp_sum = vecs[7].sum;

    // Randomized runs scored against the schedule model
    for (int i = 0; i < 20; i++) begin
      int we;
      int re;
      int cnt;
      int ovf;
      rv.a         = $urandom;
      rv.b         = $urandom;
      rv.w         = $urandom_range(0, 40);
      rv.r         = $urandom_range(0, 4);
      rv.pattern   = $urandom_range(1, 3);
      rv.abort_c   = -1;
      rv.restart_c = $urandom_range(2, 6);
      fill_wave(rv.pattern);
      we = (rv.w == 0) ? 1 : rv.w;
      re = (rv.r == 0) ? 1 : rv.r;
      rv.lat = 2 + re * (S + we + 1);
      model_edges(we, re, -1, rv.lat, cnt, ovf);
      rv.edges = cnt;
      rv.ovf   = ovf;
      rv.sum   = rv.a + rv.b;
      exp_sum  = rv.sum;
      run($sformatf("rnd%0d", i), rv, 1'b1);
    end

    // Reset in the middle of MEASURE, between sampling edges
    fill_wave(1);
    @(negedge clk);
    a_value       = 32'd77;
    b_value       = 32'd88;
    window_cycles = 16'd30;
    repeats       = 8'd1;
    start         = 1'b1;
    ring_in       = wave[0];
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start   = 1'b0;
      ring_in = wave[c];
    end
    check("pre_reset/edge_count", 64'(edge_count), 64'(1));
    check("pre_reset/ring_enable", 64'(ring_enable), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_reset/busy", 64'(busy), 64'(0));
    check("mid_reset/ring_enable", 64'(ring_enable), 64'(0));
    check("mid_reset/edge_count", 64'(edge_count), 64'(0));
    check("mid_reset/sum_capture", 64'(sum_capture), 64'(0));
    check("mid_reset/a_input", 64'(a_input), 64'(0));
    check("mid_reset/done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      check("post_reset/idle_cycles_with_activity", 64'(seen), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
